// File: rtl/pipe_regs.sv
// Four-stage pipeline register chain (IF/ID, ID/EX, EX/MEM, MEM/WB) with stall/flush/retire counters.
// Latency: one clock per stage; an instruction loaded into IF/ID reaches WB three edges later.
// Backpressure: per-stage enable holds a register; per-stage clear injects a bubble and wins over the enable.
module pipe_regs #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_reset_if,
    input  logic        i_reset_id,
    input  logic        i_reset_ex,
    input  logic        i_reset_mem,
    input  logic        i_enable_if,
    input  logic        i_enable_id,
    input  logic        i_enable_ex,
    input  logic        i_enable_mem,
    input  logic [31:0] i_pc_if,
    input  logic [31:0] i_instr_if,
    input  logic        i_rd_wren_id,
    input  logic        i_cnt_clr,
    output logic [31:0] pc_id,
    output logic [31:0] pc_ex,
    output logic [31:0] instr_id,
    output logic [31:0] instr_ex,
    output logic [31:0] instr_mem,
    output logic [31:0] instr_wb,
    output logic        valid_id,
    output logic        valid_ex,
    output logic        valid_mem,
    output logic        valid_wb,
    output logic        rd_wren_ex,
    output logic        rd_wren_mem,
    output logic        rd_wren_wb,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count,
    output logic [31:0] retired_count
);

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == CNT_MAX) ? CNT_MAX : value + 32'd1;
    endfunction

    // A stall is only counted when it actually freezes a live instruction in ID.
    logic stall_evt;
    logic flush_evt;
    assign stall_evt = i_reset_if && !i_enable_if && valid_id;
    assign flush_evt = !i_reset_if;

    // IF/ID register: captures the fetched instruction; clear beats enable.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            instr_id <= NOP_INSTR;
            pc_id    <= 32'd0;
            valid_id <= 1'b0;
        end else if (!i_reset_if) begin
            instr_id <= NOP_INSTR;
            pc_id    <= 32'd0;
            valid_id <= 1'b0;
        end else if (i_enable_if) begin
            instr_id <= i_instr_if;
            pc_id    <= i_pc_if;
            valid_id <= 1'b1;
        end
    end

    // ID/EX register: register-write flag is qualified so bubbles never write back.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            instr_ex   <= NOP_INSTR;
            pc_ex      <= 32'd0;
            valid_ex   <= 1'b0;
            rd_wren_ex <= 1'b0;
        end else if (!i_reset_id) begin
            instr_ex   <= NOP_INSTR;
            pc_ex      <= 32'd0;
            valid_ex   <= 1'b0;
            rd_wren_ex <= 1'b0;
        end else if (i_enable_id) begin
            instr_ex   <= instr_id;
            pc_ex      <= pc_id;
            valid_ex   <= valid_id;
            rd_wren_ex <= i_rd_wren_id && valid_id;
        end
    end

    // EX/MEM register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            instr_mem   <= NOP_INSTR;
            valid_mem   <= 1'b0;
            rd_wren_mem <= 1'b0;
        end else if (!i_reset_ex) begin
            instr_mem   <= NOP_INSTR;
            valid_mem   <= 1'b0;
            rd_wren_mem <= 1'b0;
        end else if (i_enable_ex) begin
            instr_mem   <= instr_ex;
            valid_mem   <= valid_ex;
            rd_wren_mem <= rd_wren_ex;
        end
    end

    // MEM/WB register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            instr_wb   <= NOP_INSTR;
            valid_wb   <= 1'b0;
            rd_wren_wb <= 1'b0;
        end else if (!i_reset_mem) begin
            instr_wb   <= NOP_INSTR;
            valid_wb   <= 1'b0;
            rd_wren_wb <= 1'b0;
        end else if (i_enable_mem) begin
            instr_wb   <= instr_mem;
            valid_wb   <= valid_mem;
            rd_wren_wb <= rd_wren_mem;
        end
    end

    // Event counters: clear has priority over any increment in the same cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stall_count   <= 32'd0;
            flush_count   <= 32'd0;
            retired_count <= 32'd0;
        end else if (i_cnt_clr) begin
            stall_count   <= 32'd0;
            flush_count   <= 32'd0;
            retired_count <= 32'd0;
        end else begin
            if (stall_evt) stall_count   <= sat_inc(stall_count);
            if (flush_evt) flush_count   <= sat_inc(flush_count);
            if (valid_wb)  retired_count <= sat_inc(retired_count);
        end
    end

endmodule

// File: tb/tb_pipe_regs.sv
module tb_pipe_regs;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk;
    logic        i_reset;
    logic        i_reset_if, i_reset_id, i_reset_ex, i_reset_mem;
    logic        i_enable_if, i_enable_id, i_enable_ex, i_enable_mem;
    logic [31:0] i_pc_if, i_instr_if;
    logic        i_rd_wren_id, i_cnt_clr;
    logic [31:0] pc_id, pc_ex, instr_id, instr_ex, instr_mem, instr_wb;
    logic        valid_id, valid_ex, valid_mem, valid_wb;
    logic        rd_wren_ex, rd_wren_mem, rd_wren_wb;
    logic [31:0] stall_count, flush_count, retired_count;

    int checks;
    int failures;

    pipe_regs #(.NOP_INSTR(NOP)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_reset_if(i_reset_if), .i_reset_id(i_reset_id),
        .i_reset_ex(i_reset_ex), .i_reset_mem(i_reset_mem),
        .i_enable_if(i_enable_if), .i_enable_id(i_enable_id),
        .i_enable_ex(i_enable_ex), .i_enable_mem(i_enable_mem),
        .i_pc_if(i_pc_if), .i_instr_if(i_instr_if),
        .i_rd_wren_id(i_rd_wren_id), .i_cnt_clr(i_cnt_clr),
        .pc_id(pc_id), .pc_ex(pc_ex),
        .instr_id(instr_id), .instr_ex(instr_ex), .instr_mem(instr_mem), .instr_wb(instr_wb),
        .valid_id(valid_id), .valid_ex(valid_ex), .valid_mem(valid_mem), .valid_wb(valid_wb),
        .rd_wren_ex(rd_wren_ex), .rd_wren_mem(rd_wren_mem), .rd_wren_wb(rd_wren_wb),
        .stall_count(stall_count), .flush_count(flush_count), .retired_count(retired_count)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_reset_if = 1'b1; i_reset_id = 1'b1; i_reset_ex = 1'b1; i_reset_mem = 1'b1;
        i_enable_if = 1'b0; i_enable_id = 1'b1; i_enable_ex = 1'b1; i_enable_mem = 1'b1;
        i_pc_if = 32'h0; i_instr_if = NOP; i_rd_wren_id = 1'b0; i_cnt_clr = 1'b0;
        tick(3);
        checks++; if (valid_id !== 1'b0 || valid_ex !== 1'b0 || valid_mem !== 1'b0 || valid_wb !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b%b%b%b exp=0000", valid_id, valid_ex, valid_mem, valid_wb); end
        checks++; if (instr_id !== NOP || instr_ex !== NOP || instr_mem !== NOP || instr_wb !== NOP) begin
            failures++; $display("FAIL reset_instr got=%h %h %h %h exp=%h", instr_id, instr_ex, instr_mem, instr_wb, NOP); end
        checks++; if (pc_id !== 32'h0 || pc_ex !== 32'h0 || rd_wren_wb !== 1'b0) begin
            failures++; $display("FAIL reset_pc got=%h %h wren=%b exp=0", pc_id, pc_ex, rd_wren_wb); end
        checks++; if (stall_count !== 32'h0 || flush_count !== 32'h0 || retired_count !== 32'h0) begin
            failures++; $display("FAIL reset_counters got=%h %h %h exp=0", stall_count, flush_count, retired_count); end
        #2 i_reset = 1'b1;
        tick(1);
        checks++; if (valid_id !== 1'b0 || retired_count !== 32'h0) begin
            failures++; $display("FAIL reset_release got valid_id=%b retired=%h exp 0/0", valid_id, retired_count); end
    endtask

    task automatic test_stream();
        i_instr_if = 32'h0010_0093; i_pc_if = 32'h0; i_enable_if = 1'b1; i_rd_wren_id = 1'b1;
        tick(1);
        checks++; if (instr_id !== 32'h0010_0093 || valid_id !== 1'b1 || pc_id !== 32'h0) begin
            failures++; $display("FAIL stream_id got=%h v=%b pc=%h exp=00100093 1 0", instr_id, valid_id, pc_id); end
        i_instr_if = NOP; i_pc_if = 32'h4;
        tick(1);
        checks++; if (instr_ex !== 32'h0010_0093 || valid_ex !== 1'b1 || rd_wren_ex !== 1'b1 || pc_ex !== 32'h0) begin
            failures++; $display("FAIL stream_ex got=%h v=%b w=%b pc=%h exp=00100093 1 1 0", instr_ex, valid_ex, rd_wren_ex, pc_ex); end
        tick(2);
        checks++; if (instr_wb !== 32'h0010_0093 || valid_wb !== 1'b1 || rd_wren_wb !== 1'b1) begin
            failures++; $display("FAIL stream_wb got=%h v=%b w=%b exp=00100093 1 1", instr_wb, valid_wb, rd_wren_wb); end
        checks++; if (retired_count !== 32'd0) begin
            failures++; $display("FAIL stream_retired_pre got=%0d exp=0", retired_count); end
        tick(1);
        checks++; if (retired_count !== 32'd1 || instr_wb !== NOP) begin
            failures++; $display("FAIL stream_retired got=%0d wb=%h exp=1 %h", retired_count, instr_wb, NOP); end
    endtask

    task automatic test_stall();
        i_instr_if = 32'h0020_8133; i_pc_if = 32'h10;
        tick(1);
        i_enable_if = 1'b0; i_reset_id = 1'b0;
        tick(1);
        checks++; if (instr_id !== 32'h0020_8133 || pc_id !== 32'h10 || instr_ex !== NOP || valid_ex !== 1'b0) begin
            failures++; $display("FAIL stall_1 got id=%h pc=%h ex=%h v=%b", instr_id, pc_id, instr_ex, valid_ex); end
        checks++; if (valid_mem !== 1'b1 || stall_count !== 32'd1) begin
            failures++; $display("FAIL stall_1_adv got valid_mem=%b stall=%0d exp 1 1", valid_mem, stall_count); end
        tick(1);
        checks++; if (instr_id !== 32'h0020_8133 || instr_ex !== NOP || valid_ex !== 1'b0 || valid_mem !== 1'b0) begin
            failures++; $display("FAIL stall_2 got id=%h ex=%h vex=%b vmem=%b", instr_id, instr_ex, valid_ex, valid_mem); end
        checks++; if (stall_count !== 32'd2) begin
            failures++; $display("FAIL stall_count got=%0d exp=2", stall_count); end
        i_enable_if = 1'b1; i_reset_id = 1'b1; i_instr_if = NOP; i_pc_if = 32'h14;
        tick(1);
        checks++; if (instr_ex !== 32'h0020_8133 || pc_ex !== 32'h10 || valid_ex !== 1'b1 || pc_id !== 32'h14 || stall_count !== 32'd2) begin
            failures++; $display("FAIL stall_release got ex=%h pc=%h v=%b pcid=%h stall=%0d", instr_ex, pc_ex, valid_ex, pc_id, stall_count); end
    endtask

    task automatic test_flush();
        i_reset_if = 1'b0; i_reset_id = 1'b0;
        tick(1);
        checks++; if (valid_id !== 1'b0 || valid_ex !== 1'b0 || instr_id !== NOP || instr_ex !== NOP || pc_id !== 32'h0) begin
            failures++; $display("FAIL flush_regs got vid=%b vex=%b id=%h ex=%h pc=%h", valid_id, valid_ex, instr_id, instr_ex, pc_id); end
        checks++; if (flush_count !== 32'd1 || stall_count !== 32'd2) begin
            failures++; $display("FAIL flush_count got=%0d stall=%0d exp 1 2", flush_count, stall_count); end
        checks++; if (instr_mem !== 32'h0020_8133 || valid_mem !== 1'b1 || rd_wren_mem !== 1'b1) begin
            failures++; $display("FAIL flush_mem got=%h v=%b w=%b exp 00208133 1 1", instr_mem, valid_mem, rd_wren_mem); end
        i_reset_if = 1'b1; i_reset_id = 1'b1;
    endtask

    task automatic test_clear_vs_enable();
        i_instr_if = 32'h0030_0193; i_pc_if = 32'h20;
        tick(1);
        i_instr_if = NOP; i_pc_if = 32'h24;
        tick(1);
        checks++; if (instr_ex !== 32'h0030_0193 || valid_ex !== 1'b1 || rd_wren_ex !== 1'b1) begin
            failures++; $display("FAIL cve_setup got=%h v=%b w=%b", instr_ex, valid_ex, rd_wren_ex); end
        i_reset_ex = 1'b0;
        tick(1);
        checks++; if (valid_mem !== 1'b0 || rd_wren_mem !== 1'b0 || instr_mem !== NOP) begin
            failures++; $display("FAIL cve_ex got v=%b w=%b instr=%h exp 0 0 %h", valid_mem, rd_wren_mem, instr_mem, NOP); end
        i_reset_ex = 1'b1;
        i_reset_if = 1'b0; i_enable_if = 1'b0;
        tick(1);
        checks++; if (valid_id !== 1'b0 || instr_id !== NOP || flush_count !== 32'd2 || stall_count !== 32'd2) begin
            failures++; $display("FAIL cve_if got v=%b id=%h flush=%0d stall=%0d exp 0 %h 2 2", valid_id, instr_id, flush_count, stall_count, NOP); end
        i_reset_if = 1'b1;
    endtask

    task automatic test_saturation();
        i_instr_if = 32'h0040_0213; i_pc_if = 32'h30; i_enable_if = 1'b1;
        tick(1);
        i_enable_if = 1'b0;
        #1 force dut.stall_count = 32'hFFFF_FFFE;
        #1 release dut.stall_count;
        tick(1);
        checks++; if (stall_count !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL sat_reach got=%h exp=ffffffff", stall_count); end
        tick(2);
        checks++; if (stall_count !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL sat_hold got=%h exp=ffffffff", stall_count); end
        i_cnt_clr = 1'b1;
        tick(1);
        checks++; if (stall_count !== 32'h0 || flush_count !== 32'h0 || retired_count !== 32'h0) begin
            failures++; $display("FAIL cnt_clr got=%h %h %h exp=0", stall_count, flush_count, retired_count); end
        checks++; if (instr_id !== 32'h0040_0213 || valid_id !== 1'b1 || pc_id !== 32'h30) begin
            failures++; $display("FAIL cnt_clr_pipe got=%h v=%b pc=%h exp 00400213 1 30", instr_id, valid_id, pc_id); end
        i_cnt_clr = 1'b0;
        tick(1);
        checks++; if (stall_count !== 32'd1) begin
            failures++; $display("FAIL cnt_resume got=%0d exp=1", stall_count); end
    endtask

    task automatic test_async_reset();
        i_enable_if = 1'b1; i_instr_if = 32'h0050_0293; i_pc_if = 32'h40;
        tick(4);
        checks++; if (valid_id !== 1'b1 || valid_ex !== 1'b1 || valid_mem !== 1'b1 || valid_wb !== 1'b1) begin
            failures++; $display("FAIL async_fill got=%b%b%b%b exp=1111", valid_id, valid_ex, valid_mem, valid_wb); end
        i_enable_if = 1'b0;
        tick(1);
        #2 i_reset = 1'b0;
        #1;
        checks++; if (valid_id !== 1'b0 || valid_ex !== 1'b0 || valid_mem !== 1'b0 || valid_wb !== 1'b0) begin
            failures++; $display("FAIL async_valid got=%b%b%b%b exp=0000", valid_id, valid_ex, valid_mem, valid_wb); end
        checks++; if (instr_id !== NOP || instr_ex !== NOP || instr_mem !== NOP || instr_wb !== NOP || pc_id !== 32'h0 || pc_ex !== 32'h0) begin
            failures++; $display("FAIL async_instr got=%h %h %h %h pc=%h %h", instr_id, instr_ex, instr_mem, instr_wb, pc_id, pc_ex); end
        checks++; if (stall_count !== 32'h0 || flush_count !== 32'h0 || retired_count !== 32'h0 || rd_wren_ex !== 1'b0) begin
            failures++; $display("FAIL async_counters got=%h %h %h w=%b exp=0", stall_count, flush_count, retired_count, rd_wren_ex); end
        #2 i_reset = 1'b1;
        tick(1);
        checks++; if (valid_id !== 1'b0 || stall_count !== 32'h0 || valid_ex !== 1'b0) begin
            failures++; $display("FAIL async_post got vid=%b stall=%0d vex=%b exp 0 0 0", valid_id, stall_count, valid_ex); end
        i_enable_if = 1'b1; i_instr_if = 32'h0060_0313; i_pc_if = 32'h50;
        tick(1);
        checks++; if (instr_id !== 32'h0060_0313 || valid_id !== 1'b1 || pc_id !== 32'h50 || stall_count !== 32'h0) begin
            failures++; $display("FAIL async_resume got=%h v=%b pc=%h stall=%0d", instr_id, valid_id, pc_id, stall_count); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_clear_vs_enable();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
